// File: rtl/ram_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl_if
// Description : Bundles the BIST control handshake and the single-port RAM
//               bus seen by ram_bist_ctrl.
//   master : the BIST controller. It receives start and ram_q, and drives
//            ram_addr, ram_data, ram_we, busy, done, pass and fail_addr.
//   slave  : the requester and RAM side (the mirror image of master).
// Revision    : 1.0  initial release
// ============================================================================
interface ram_bist_ctrl_if #(
  parameter int addr_width = 6,
  parameter int data_width = 8
);
  logic                  start;
  logic [addr_width-1:0] ram_addr;
  logic [data_width-1:0] ram_data;
  logic                  ram_we;
  logic [data_width-1:0] ram_q;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [addr_width-1:0] fail_addr;

  modport master (
    input  start, ram_q,
    output ram_addr, ram_data, ram_we, busy, done, pass, fail_addr
  );

  modport slave (
    output start, ram_q,
    input  ram_addr, ram_data, ram_we, busy, done, pass, fail_addr
  );
endinterface
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Write/read-back BIST for a single-port RAM that has a 1-cycle
//               read latency. Each address a is written with (a+1). The words
//               are then read back and compared. The address of the first
//               mismatch is kept.
//               Optional feature: BIST_INVERT_PASS_EN. When this macro is
//               defined, a second pass runs with the inverted pattern before
//               the block reports done.
// Ports       : clk, rst (async, active-high)
//               bus.start             - one-cycle run request (ignored while busy)
//               bus.ram_addr/data/we  - RAM address, write data, write enable
//               bus.ram_q             - RAM read data (one cycle after address)
//               bus.busy/done/pass    - run status
//               bus.fail_addr         - address of the first mismatching word
// Revision    : 1.0  initial release
// ============================================================================
module ram_bist_ctrl #(
  parameter int addr_width = 6,
  parameter int data_width = 8,
  parameter int depth      = 64
) (
  input  logic            clk,
  input  logic            rst,
  ram_bist_ctrl_if.master bus
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [addr_width-1:0] cnt, cnt_next;
  logic                  inv, inv_next;      // second (inverted) pass active
  logic                  run_start;
  logic [data_width-1:0] pattern;
  logic                  we;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] wdata;

  // Expected word for the read issued last cycle, lined up with ram_q.
  logic                  exp_valid;
  logic [data_width-1:0] exp_data;
  logic [addr_width-1:0] exp_addr;
  logic                  err_seen;
  logic [addr_width-1:0] fail_addr_q;

  // P(a) = a+1 modulo 2**data_width, bitwise inverted in the second pass.
  always_comb begin
    pattern = data_width'(cnt) + data_width'(1);
    if (inv) begin
      pattern = ~pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    inv_next   = inv;
    run_start  = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = WRITE;
          cnt_next   = '0;
          inv_next   = 1'b0;
          run_start  = 1'b1;
        end
      end
      WRITE: begin
        we    = 1'b1;
        addr  = cnt;
        wdata = pattern;
        if (cnt == LAST_ADDR) begin
          state_next = READ;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + addr_width'(1);
        end
      end
      READ: begin
        addr = cnt;
        // The counter parks on the last address rather than wrapping.
        if (cnt == LAST_ADDR) begin
          state_next = DRAIN;
        end else begin
          cnt_next = cnt + addr_width'(1);
        end
      end
      DRAIN: begin
`ifdef BIST_INVERT_PASS_EN
        if (!inv) begin
          state_next = WRITE;
          cnt_next   = '0;
          inv_next   = 1'b1;
        end else begin
          state_next = DONE;
        end
`else
        state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      inv         <= 1'b0;
      exp_valid   <= 1'b0;
      exp_data    <= '0;
      exp_addr    <= '0;
      err_seen    <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      cnt       <= cnt_next;
      inv       <= inv_next;
      exp_valid <= (state == READ);
      exp_data  <= pattern;
      exp_addr  <= cnt;
      if (run_start) begin
        err_seen    <= 1'b0;
        fail_addr_q <= '0;
      end else if (exp_valid && (bus.ram_q != exp_data) && !err_seen) begin
        // Only the first mismatch of the whole run is recorded.
        err_seen    <= 1'b1;
        fail_addr_q <= exp_addr;
      end
    end
  end

  assign bus.ram_we    = we;
  assign bus.ram_addr  = addr;
  assign bus.ram_data  = wdata;
  assign bus.busy      = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && !err_seen;
  assign bus.fail_addr = fail_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bist_ctrl
// Description : Self-checking bench for ram_bist_ctrl. It contains a RAM model
//               with per-address stuck-at masks. A table of directed fault
//               cases, the start and reset corner cases, and random fault
//               sets are checked against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
`ifdef BIST_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int RUN_CYCLES = PASSES * (2 * DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bist_ctrl_if #(.addr_width(AW), .data_width(DW)) bus ();

  ram_bist_ctrl #(.addr_width(AW), .data_width(DW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: writes at the edge, and the read data shows the addressed
  // word one edge later. The masks force single bits to 1 or to 0.
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] or_m  [DEPTH];
  logic [DW-1:0] and_m [DEPTH];
  logic [DW-1:0] q;
  logic [AW+DW-1:0] wq [$];

  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr] <= bus.ram_data;
      wq.push_back({bus.ram_addr, bus.ram_data});
    end
    q <= (mem[bus.ram_addr] | or_m[bus.ram_addr]) & ~and_m[bus.ram_addr];
  end
  assign bus.ram_q = q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a, input bit inverted);
    logic [DW-1:0] v;
    v = DW'((a + 1) % (1 << DW));
    return inverted ? ~v : v;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      or_m[i]  = '0;
      and_m[i] = '0;
    end
  endtask

  // Reference result: the first address whose read-back differs from the
  // written pattern. Pass 1 is scanned before pass 2.
  task automatic model(output logic exp_pass, output int exp_fail);
    exp_pass = 1'b1;
    exp_fail = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (exp_pass && (((pat(a, p == 1) | or_m[a]) & ~and_m[a]) != pat(a, p == 1))) begin
          exp_pass = 1'b0;
          exp_fail = a;
        end
      end
    end
  endtask

  task automatic run_bist(input int repulse, input logic exp_pass, input int exp_fail, input string tag);
    int base;
    int cycles;
    int bad;
    int n;
    base   = wq.size();
    cycles = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, ":start_status"}, {bus.busy, bus.done, bus.pass, 26'(bus.fail_addr)}, {3'b100, 26'd0});
    while (bus.busy === 1'b1 && cycles < RUN_CYCLES + 50) begin
      cycles++;
      bus.start = (cycles == repulse);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check({tag, ":busy_cycles"}, cycles, RUN_CYCLES);
    check({tag, ":done"}, {bus.busy, bus.done}, 2'b01);
    check({tag, ":pass"}, bus.pass, exp_pass);
    if (!exp_pass) begin
      check({tag, ":fail_addr"}, bus.fail_addr, exp_fail);
    end
    n   = wq.size() - base;
    bad = 0;
    for (int i = 0; i < n && i < PASSES * DEPTH; i++) begin
      if (wq[base + i] !== {AW'(i % DEPTH), pat(i % DEPTH, (i / DEPTH) == 1)}) begin
        if (bad == 0) begin
          $display("FAIL %s:write[%0d] got %0h, expected %0h", tag, i, wq[base + i],
                   {AW'(i % DEPTH), pat(i % DEPTH, (i / DEPTH) == 1)});
        end
        bad++;
      end
    end
    check({tag, ":write_count"}, n, PASSES * DEPTH);
    check({tag, ":write_errors"}, bad, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ":done_hold"}, {bus.done, bus.pass}, {1'b1, exp_pass});
  endtask

  typedef struct {
    int           fa;       // first faulty address, -1 for none
    logic [DW-1:0] ma;      // stuck-at-1 mask at fa
    int           fb;
    logic [DW-1:0] mb;
    int           repulse;  // busy cycle on which start is pulsed again, 0 for none
    logic         exp_pass;
    int           exp_fail;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mp;
    int   mf;
    int   k;
    int   a;
    int   rp;

    vecs[0] = '{fa: -1, ma: 8'h00, fb: -1, mb: 8'h00, repulse: 0,  exp_pass: 1'b1, exp_fail: 0};
    vecs[1] = '{fa: 5,  ma: 8'h01, fb: -1, mb: 8'h00, repulse: 0,  exp_pass: 1'b0, exp_fail: 5};
    vecs[2] = '{fa: 9,  ma: 8'h01, fb: 3,  mb: 8'h01, repulse: 0,  exp_pass: 1'b0, exp_fail: 3};
    vecs[3] = '{fa: -1, ma: 8'h00, fb: -1, mb: 8'h00, repulse: 10, exp_pass: 1'b1, exp_fail: 0};
    vecs[4] = '{fa: 63, ma: 8'h80, fb: -1, mb: 8'h00, repulse: 0,  exp_pass: 1'b0, exp_fail: 63};
    vecs[5] = '{fa: 0,  ma: 8'h02, fb: 40, mb: 8'h01, repulse: 0,  exp_pass: 1'b0, exp_fail: 0};

    bus.start = 1'b0;
    clear_faults();
    rst = 1'b1;
    #1;
    check("reset_outputs",
          {bus.ram_we, bus.busy, bus.done, bus.pass, 6'(bus.ram_addr), 8'(bus.ram_data), 6'(bus.fail_addr)},
          24'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", {bus.busy, bus.done}, 2'b00);

    for (int v = 0; v < 6; v++) begin
      clear_faults();
      if (vecs[v].fa >= 0) or_m[vecs[v].fa] = vecs[v].ma;
      if (vecs[v].fb >= 0) or_m[vecs[v].fb] = vecs[v].mb;
      run_bist(vecs[v].repulse, vecs[v].exp_pass, vecs[v].exp_fail, $sformatf("vec%0d", v));
    end

    // Reset in the middle of the write phase.
    clear_faults();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("rst_mid:writing", {bus.ram_we, 6'(bus.ram_addr)}, {1'b1, 6'd19});
    rst = 1'b1;
    #1;
    check("rst_mid:async_outputs", {bus.ram_we, bus.busy, bus.done, 8'(bus.ram_data)}, 11'd0);
    k = wq.size();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid:stays_idle", {bus.busy, bus.done}, 2'b00);
    check("rst_mid:no_writes", wq.size(), k);
    run_bist(0, 1'b1, 0, "after_rst");

    // Random stuck-at faults checked against the reference model.
    for (int r = 0; r < 20; r++) begin
      clear_faults();
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        a = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) or_m[a] = or_m[a] | DW'(1 << $urandom_range(0, DW - 1));
        else                           and_m[a] = and_m[a] | DW'(1 << $urandom_range(0, DW - 1));
      end
      model(mp, mf);
      rp = ($urandom_range(0, 1) == 1) ? $urandom_range(2, RUN_CYCLES - 1) : 0;
      run_bist(rp, mp, mf, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 The block SHALL have parameter addr_width, default 6, RAM address width.
REQ-002 The block SHALL have parameter data_width, default 8, RAM data width.
REQ-003 The block SHALL have parameter depth, default 64, number of RAM words tested (depth <= 2**addr_width).
REQ-004 The block SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin a test run.
REQ-007 The block SHALL have port ram_addr, output, addr_width, the address driven to the single-port RAM addr input.
REQ-008 The block SHALL have port ram_data, output, data_width, the write data driven to the RAM data input.
REQ-009 The block SHALL have port ram_we, output, 1, the RAM write enable.
REQ-010 The block SHALL have port ram_q, input, data_width, the RAM read data.
REQ-011 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 The block SHALL have port done, output, 1, high from run completion until the next start or reset.
REQ-013 The block SHALL have port pass, output, 1, valid while done is high; 1 means no mismatch.
REQ-014 The block SHALL have port fail_addr, output, addr_width, the address of the first mismatch; valid when done=1 and pass=0.

Function
REQ-015 The block SHALL assume RAM timing of a write at the clock edge when ram_we=1, and ram_q reflecting the word at the ram_addr sampled one edge earlier (1-cycle read latency).
REQ-016 The block SHALL use pattern P(a) = (a+1) mod 2**data_width for address a, e.g. 0->8'h01, 1->8'h02, 2->8'h03.
REQ-017 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE.
REQ-018 In IDLE or DONE, when start=1 the FSM SHALL go to WRITE, clear done, pass and fail_addr, and set the address counter to 0.
REQ-019 In WRITE the block SHALL drive ram_we=1, ram_addr=counter and ram_data=P(counter) for depth cycles (address 0..depth-1), then go to READ with the counter at 0.
REQ-020 In READ the block SHALL drive ram_we=0 and ram_addr=counter for depth cycles.
REQ-021 The block SHALL register the expected data and address one cycle behind the issued read address.
REQ-022 The block SHALL compare ram_q against the registered expected value in the cycle after each read is issued; the last compare occurs in DRAIN (1 cycle).
REQ-023 On the first mismatch the block SHALL latch fail_addr; later mismatches SHALL NOT overwrite it; the run SHALL continue to the end.
REQ-024 After DRAIN the FSM SHALL enter DONE with done=1, busy=0, and pass=1 only if zero mismatches occurred.
REQ-025 The block SHALL hold busy=1 in WRITE, READ and DRAIN; a base run SHALL take 2*depth+1 busy cycles.
REQ-026 The block SHALL ignore start while busy=1.
REQ-027 The block SHALL drive ram_we=0 outside WRITE, and ram_data=0 whenever ram_we=0.
REQ-028 The address counter SHALL stop at depth-1 and SHALL NOT wrap while in a pass.

Reset
REQ-029 On rst=1, asynchronously, the block SHALL enter IDLE and set ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0, pass=0 and fail_addr=0.
REQ-030 When rst is asserted mid-run, the block SHALL abort the run with no write after assertion, and SHALL require a new start after release.

Configuration
REQ-031 When macro BIST_INVERT_PASS_EN is defined, after the first DRAIN the block SHALL repeat WRITE/READ/DRAIN with pattern ~P(a) before DONE, for a total of 4*depth+2 busy cycles.
REQ-032 In the inverted second pass, fail_addr SHALL keep a first-pass failure if one exists.
REQ-033 When BIST_INVERT_PASS_EN is undefined, the block SHALL run only the P(a) pass.

Verification
REQ-034 The bench SHALL cover: a good RAM, start pulse -> writes 01,02,...,40h at addresses 0..63, then done=1 and pass=1 after 129 busy cycles.
REQ-035 The bench SHALL cover: a RAM model with bit 0 stuck at 1 at address 5 (reads 07h) -> pass=0 and fail_addr=5.
REQ-036 The bench SHALL cover: faults at addresses 9 and 3 -> fail_addr=3, which is the first compared.
REQ-037 The bench SHALL cover: start re-pulsed at cycle 10 of a run -> ignored, with completion still at cycle 129.
REQ-038 The bench SHALL cover: rst at cycle 20 of WRITE -> ram_we=0 immediately, with busy=0 and done=0; a new start then completes with pass=1.
REQ-039 The bench SHALL cover: BIST_INVERT_PASS_EN defined with a good RAM -> second pass writes FEh,FDh,... and completes with pass=1 after 258 busy cycles.
